// File: rtl/button_press_decoder_if.sv
// rtl/button_press_decoder_if.sv - press/release pulse inputs and control outputs of the button decoder
interface button_press_decoder_if;
    logic press_i;
    logic release_i;
    logic start_stop_pulse_o;
    logic clear_pulse_o;
    logic running_o;
    logic busy_o;

    modport master (
        output press_i,
        output release_i,
        input  start_stop_pulse_o,
        input  clear_pulse_o,
        input  running_o,
        input  busy_o
    );

    modport slave (
        input  press_i,
        input  release_i,
        output start_stop_pulse_o,
        output clear_pulse_o,
        output running_o,
        output busy_o
    );
endinterface

// File: rtl/button_press_decoder.sv
// rtl/button_press_decoder.sv - classifies button holds as short (run/stop toggle) or long (clear)
module button_press_decoder #(
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int CNT_W             = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    button_press_decoder_if.slave bus
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESSED   = 2'd1;
    localparam logic [1:0] ST_LONG_HELD = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_stop_q, start_stop_d;
    logic             clear_q, clear_d;
    logic             running_q, running_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_stop_d = 1'b0;
        clear_d      = 1'b0;
        running_d    = running_q;
        case (state_q)
            ST_IDLE: begin
                // Simultaneous press and release cannot be classified, so both are dropped.
                if (bus.press_i && !bus.release_i) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end
            end
            ST_PRESSED: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (bus.release_i) begin
                    start_stop_d = 1'b1;
                    running_d    = ~running_q;
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                end else if (cnt_q == CNT_LAST) begin
                    clear_d   = 1'b1;
                    running_d = 1'b0;
                    state_d   = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (bus.release_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            start_stop_q <= 1'b0;
            clear_q      <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_stop_q <= start_stop_d;
            clear_q      <= clear_d;
            running_q    <= running_d;
        end
    end

    assign bus.start_stop_pulse_o = start_stop_q;
    assign bus.clear_pulse_o      = clear_q;
    assign bus.running_o          = running_q;
    assign bus.busy_o             = (state_q != ST_IDLE);
endmodule

// File: tb/tb_button_press_decoder.sv
// tb/tb_button_press_decoder.sv - directed checks of short/long press classification
module tb_button_press_decoder;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    button_press_decoder_if bif ();

    button_press_decoder #(
        .LONG_PRESS_CYCLES(8),
        .CNT_W            (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector order: {start_stop_pulse, clear_pulse, running, busy}
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic p, input logic r, input logic [3:0] exp, input string tag);
        bif.press_i   = p;
        bif.release_i = r;
        @(posedge clk);
        #1;
        bif.press_i   = 1'b0;
        bif.release_i = 1'b0;
        check(tag, {bif.start_stop_pulse_o, bif.clear_pulse_o, bif.running_o, bif.busy_o}, exp);
    endtask

    // Press at edge 0, idle for hold-1 edges, release at edge 'hold'; running goes from run to ~run.
    task automatic short_press(input int hold, input logic run, input string tag);
        step(1'b1, 1'b0, {2'b00, run, 1'b1}, {tag, "_press"});
        for (int i = 1; i < hold; i++) step(1'b0, 1'b0, {2'b00, run, 1'b1}, {tag, "_hold"});
        step(1'b0, 1'b1, {2'b10, ~run, 1'b0}, {tag, "_release"});
        step(1'b0, 1'b0, {2'b00, ~run, 1'b0}, {tag, "_after"});
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bif.press_i   = 1'b0;
        bif.release_i = 1'b0;

        // 1. reset then idle
        step(1'b0, 1'b0, 4'b0000, "reset0");
        step(1'b1, 1'b0, 4'b0000, "reset_overrides_press");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'b0000, "idle");

        // 2. short presses toggle running both ways
        short_press(3, 1'b0, "short_on");
        short_press(3, 1'b1, "short_off");

        // 3. long press from running=1
        short_press(2, 1'b0, "pre_long");
        step(1'b1, 1'b0, 4'b0011, "long_press");
        for (int i = 1; i < 8; i++) step(1'b0, 1'b0, 4'b0011, "long_hold_pre");
        step(1'b0, 1'b0, 4'b0101, "long_clear");
        for (int i = 9; i < 20; i++) step(1'b0, 1'b0, 4'b0001, "long_held");
        step(1'b0, 1'b1, 4'b0000, "long_release");
        step(1'b0, 1'b0, 4'b0000, "long_after");

        // 4. release on the threshold edge counts as short
        short_press(8, 1'b0, "tie");

        // 5. stray release, simultaneous press+release, glitch press mid-hold
        step(1'b0, 1'b1, 4'b0010, "stray_release");
        step(1'b1, 1'b1, 4'b0010, "press_and_release");
        step(1'b0, 1'b0, 4'b0010, "still_idle");
        step(1'b1, 1'b0, 4'b0011, "glitch_press0");
        for (int i = 1; i < 4; i++) step(1'b0, 1'b0, 4'b0011, "glitch_hold_a");
        step(1'b1, 1'b0, 4'b0011, "glitch_press4");
        for (int i = 5; i < 8; i++) step(1'b0, 1'b0, 4'b0011, "glitch_hold_b");
        step(1'b0, 1'b0, 4'b0101, "glitch_clear_at_8");
        step(1'b1, 1'b0, 4'b0001, "long_held_press_ignored");
        step(1'b0, 1'b1, 4'b0000, "glitch_release");

        // 6. reset mid-hold with running=1, then normal operation resumes
        short_press(1, 1'b0, "pre_rst");
        step(1'b1, 1'b0, 4'b0011, "rst_hold_press");
        for (int i = 1; i < 5; i++) step(1'b0, 1'b0, 4'b0011, "rst_hold");
        rst = 1'b1;
        step(1'b0, 1'b0, 4'b0000, "rst_mid_hold");
        rst = 1'b0;
        step(1'b0, 1'b0, 4'b0000, "rst_edge6");
        step(1'b0, 1'b1, 4'b0000, "rst_late_release");
        step(1'b0, 1'b0, 4'b0000, "rst_edge8");
        step(1'b1, 1'b0, 4'b0001, "post_rst_press");
        step(1'b0, 1'b0, 4'b0001, "post_rst_hold");
        step(1'b0, 1'b1, 4'b1010, "post_rst_release");

        // back-to-back press right after returning to IDLE
        step(1'b1, 1'b0, 4'b0011, "b2b_press");
        step(1'b0, 1'b1, 4'b1000, "b2b_release");
        step(1'b0, 1'b0, 4'b0000, "b2b_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/button_press_decoder.md
Name: button_press_decoder

Overview:
Consumes the one-cycle press/release pulses produced by the edge-transition stage on the chronometer's single push-button. Classifies each press as short or long by measuring hold time. A short press toggles run/stop. A long press clears the chronometer. Outputs drive the time-counter control logic directly.

Parameters:
LONG_PRESS_CYCLES, 50000000, hold length in clk cycles that qualifies as a long press (1 s at 50 MHz); legal range 2..2^CNT_W-1
CNT_W, 26, width of the hold counter; must satisfy 2^CNT_W > LONG_PRESS_CYCLES

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
press  input  1  one-cycle pulse: button went low->high
release  input  1  one-cycle pulse: button went high->low
start_stop_pulse  output  1  one-cycle pulse on a completed short press
clear_pulse  output  1  one-cycle pulse when hold time reaches LONG_PRESS_CYCLES
running  output  1  level: chronometer run enable; toggled by short press, forced 0 by clear
busy  output  1  level: high while the button is held (state != IDLE)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). rst sampled high at an edge: state=IDLE, cnt=0, start_stop_pulse=0, clear_pulse=0, running=0, busy=0. Reset overrides every other input on that edge, including mid-hold; a hold in progress is discarded with no pulse.
- All outputs are registered. Pulses are exactly one cycle wide. busy is 1 exactly when state is PRESSED or LONG_HELD.
- States: IDLE, PRESSED, LONG_HELD.
- IDLE:
  - press=1, release=0 -> PRESSED, cnt<=0.
  - release alone is ignored (stray release).
  - press and release in the same cycle -> both ignored, stay IDLE.
- PRESSED:
  - Each edge: cnt<=cnt+1, saturating at 2^CNT_W-1.
  - release=1 -> short press. start_stop_pulse<=1 and running<=~running on that edge; -> IDLE; cnt<=0.
  - Else, if cnt==LONG_PRESS_CYCLES-1 -> clear_pulse<=1, running<=0; -> LONG_HELD.
  - Priority: when release and the threshold coincide on the same edge, release wins and the press counts as short.
  - press=1 is ignored (glitch); it does not restart cnt.
- LONG_HELD:
  - release=1 -> IDLE, no pulse.
  - press is ignored. cnt holds.
- Latency:
  - start_stop_pulse and the running toggle are visible in the cycle after the edge that samples release.
  - clear_pulse is visible in the cycle after the edge that is LONG_PRESS_CYCLES edges after the edge that sampled press.
- start_stop_pulse and clear_pulse are never high in the same cycle.
- running changes only on start_stop_pulse (toggle) or clear_pulse (to 0).
- Back-to-back: a press in the cycle immediately after the returning-to-IDLE edge is accepted normally (zero dead time).

Test Plan (LONG_PRESS_CYCLES=8, CNT_W=4):
1. Reset then idle: rst=1 for 2 cycles, then press=release=0 for 10 cycles -> all outputs 0 throughout.
2. Short press: press at edge 0, release at edge 3 -> start_stop_pulse=1 for one cycle after edge 3, running 0->1, busy 1 during edges 1-3 then 0. Repeat the press -> running 1->0.
3. Long press: running=1, press at edge 0, hold, release at edge 20 -> clear_pulse=1 for one cycle after edge 8, running=0 from that point, no start_stop_pulse at release, busy falls after edge 20.
4. Threshold tie: press at edge 0, release at edge 8 -> start_stop_pulse=1 and running toggles; clear_pulse stays 0.
5. Stray and glitch inputs: release alone in IDLE -> no change. Press and release together in IDLE -> no change. Second press at edge 4 while PRESSED -> cnt not restarted, clear_pulse still follows edge 8.
6. Reset mid-hold: press at edge 0, rst=1 at edge 5, release at edge 7 -> no pulses, running=0, state IDLE. A next press at edge 9 with release at edge 11 -> normal short press, running=1.
